// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses,
// mcause exception codes, trap FSM states and mstatus bit positions.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    localparam logic [3:0] MCAUSE_I_MISALIGN = 4'd0;
    localparam logic [3:0] MCAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] MCAUSE_L_MISALIGN = 4'd4;
    localparam logic [3:0] MCAUSE_S_MISALIGN = 4'd6;
    localparam logic [3:0] MCAUSE_ECALL_M    = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        REDIRECT
    } csr_state_t;

    // Highest-priority exception wins; callers only use this when at least one strobe is set.
    function automatic logic [3:0] trap_code(input logic i_misalign, input logic ebreak,
                                             input logic ecall, input logic l_misalign);
        if (i_misalign)      return MCAUSE_I_MISALIGN;
        else if (ebreak)     return MCAUSE_BREAKPOINT;
        else if (ecall)      return MCAUSE_ECALL_M;
        else if (l_misalign) return MCAUSE_L_MISALIGN;
        else                 return MCAUSE_S_MISALIGN;
    endfunction

    // ecall/ebreak carry no faulting address, so mtval is cleared for them.
    function automatic logic tval_is_zero(input logic [3:0] code);
        return (code == MCAUSE_BREAKPOINT) || (code == MCAUSE_ECALL_M);
    endfunction

endpackage

// File: rtl/machine_csr_unit_if.sv
// Core <-> CSR unit signals: CSR read/write port, trap event strobes and the IF redirect.
interface machine_csr_unit_if;
    logic        csr_rd_en;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        i_misalign;
    logic        l_misalign;
    logic        s_misalign;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic [31:0] pc_csr;
    logic        csr_delay;

    modport master (
        output csr_rd_en, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
               ecall, ebreak, mret, i_misalign, l_misalign, s_misalign, trap_pc, trap_tval,
        input  csr_rd_data, pc_csr, csr_delay
    );

    modport slave (
        input  csr_rd_en, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
               ecall, ebreak, mret, i_misalign, l_misalign, s_misalign, trap_pc, trap_tval,
        output csr_rd_data, pc_csr, csr_delay
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter; either 32-bit half can be loaded, which suppresses
// the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_data,
    output logic [63:0] count
);

    // Count every cycle unless a half is being overwritten.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (load_lo || load_hi) begin
            if (load_lo) count[31:0]  <= load_data;
            if (load_hi) count[63:32] <= load_data;
        end else begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/machine_csr_unit.sv
// Machine-mode CSR file and trap sequencer: register bank, read mux, exception
// priority encoder and the IDLE -> SAVE -> REDIRECT fetch-redirect FSM.
module machine_csr_unit
    import riscv_csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input logic               clk,
    input logic               reset,
    machine_csr_unit_if.slave bus
);

    csr_state_t      state;
    logic            csr_delay_q;
    logic [XLEN-1:0] pc_csr_q;

    // Trap context captured in the event cycle; the strobes are only one cycle wide.
    logic            is_mret_q;
    logic [3:0]      cause_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] tval_q;

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_reg;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [63:0]     mcycle;
    logic [XLEN-1:0] rd_data;

    logic       exc_event;
    logic       any_event;
    logic       wr_ok;
    logic [3:0] event_code;

    assign exc_event  = bus.ecall | bus.ebreak | bus.i_misalign | bus.l_misalign | bus.s_misalign;
    assign any_event  = exc_event | bus.mret;
    assign event_code = trap_code(bus.i_misalign, bus.ebreak, bus.ecall, bus.l_misalign);
    // The instruction raising an event must not commit, and nothing commits mid-trap.
    assign wr_ok      = bus.csr_wr_en && (state == IDLE) && !any_event;

    csr_counter64 u_mcycle (
        .clk       (clk),
        .reset     (reset),
        .load_lo   (wr_ok && (bus.csr_wr_addr == CSR_MCYCLE)),
        .load_hi   (wr_ok && (bus.csr_wr_addr == CSR_MCYCLEH)),
        .load_data (bus.csr_wr_data),
        .count     (mcycle)
    );

    // Trap sequencer: latch the winning event in IDLE, compute the redirect in SAVE, hold it in REDIRECT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            csr_delay_q <= 1'b0;
            pc_csr_q    <= '0;
            is_mret_q   <= 1'b0;
            cause_q     <= '0;
            epc_q       <= '0;
            tval_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_event) begin
                        state       <= SAVE;
                        csr_delay_q <= 1'b1;
                        is_mret_q   <= !exc_event;
                        cause_q     <= event_code;
                        epc_q       <= bus.trap_pc & ~32'd3;
                        tval_q      <= tval_is_zero(event_code) ? '0 : bus.trap_tval;
                    end
                end
                SAVE: begin
                    state       <= REDIRECT;
                    csr_delay_q <= 1'b1;
                    pc_csr_q    <= is_mret_q ? mepc : (mtvec & ~32'd3);
                end
                REDIRECT: begin
                    state       <= IDLE;
                    csr_delay_q <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    csr_delay_q <= 1'b0;
                end
            endcase
        end
    end

    // Register bank: trap side effects in SAVE, otherwise software writes from the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_reg      <= '0;
            mtvec        <= MTVEC_RESET;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
        end else if (state == SAVE) begin
            if (is_mret_q) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else begin
                mepc         <= epc_q;
                mcause       <= XLEN'(cause_q);
                mtval        <= tval_q;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end
        end else if (wr_ok) begin
            case (bus.csr_wr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= bus.csr_wr_data[MSTATUS_MIE];
                    mstatus_mpie <= bus.csr_wr_data[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_reg  <= bus.csr_wr_data;
                CSR_MTVEC:    mtvec    <= bus.csr_wr_data & ~32'd3;
                CSR_MSCRATCH: mscratch <= bus.csr_wr_data;
                CSR_MEPC:     mepc     <= bus.csr_wr_data & ~32'd3;
                CSR_MCAUSE:   mcause   <= bus.csr_wr_data;
                CSR_MTVAL:    mtval    <= bus.csr_wr_data;
                default: ;
            endcase
        end
    end

    // Combinational read mux; returns pre-edge values, so a same-cycle write is not visible.
    always_comb begin
        // NOTE: default first so every path assigns rd_data and no latch is inferred.
        rd_data = '0;
        if (bus.csr_rd_en) begin
            case (bus.csr_rd_addr)
                CSR_MSTATUS: begin
                    rd_data[MSTATUS_MIE]                   = mstatus_mie;
                    rd_data[MSTATUS_MPIE]                  = mstatus_mpie;
                    rd_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                end
                CSR_MISA:     rd_data = MISA_VALUE;
                CSR_MIE:      rd_data = mie_reg;
                CSR_MTVEC:    rd_data = mtvec;
                CSR_MSCRATCH: rd_data = mscratch;
                CSR_MEPC:     rd_data = mepc;
                CSR_MCAUSE:   rd_data = mcause;
                CSR_MTVAL:    rd_data = mtval;
                CSR_MCYCLE:   rd_data = mcycle[31:0];
                CSR_MCYCLEH:  rd_data = mcycle[63:32];
                CSR_MHARTID:  rd_data = HART_ID;
                default:      rd_data = '0;
            endcase
        end
    end

    assign bus.csr_rd_data = rd_data;
    assign bus.pc_csr      = pc_csr_q;
    assign bus.csr_delay   = csr_delay_q;

endmodule
